id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised ID/EX pipeline register for the multi-issue core: carries `LANES` decoded instruction bundles from decode to execute with a valid/ready handshake, per-lane valid bits, lane kill and whole-bundle flush. An optional one-entry skid buffer gives full throughput while keeping `in_ready` registered. It sits between the register-file read/immediate-extend logic and the ALU/forwarding stage, and replaces the fixed two-lane ID/EX latch.

## Interface
- `LANES`, 2, issue width (1..4)
- `DATA_W`, 32, width of DOA/DOB/imm_ext
- `REG_W`, 5, register-index width (rt, rd)
- `reloj`  in  1  clock, all state on rising edge
- `resetID_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decode presents a bundle
- `in_ready`  out  1  register can accept a bundle this cycle
- `lane_valid_in`  in  LANES  per-lane instruction present
- `lane_kill`  in  LANES  per-lane squash applied at capture (younger lanes behind a taken branch)
- `flush`  in  1  synchronous squash of every held and incoming bundle
- `ctrl_EXE`  in  LANES*5  per lane: [4:2] ALU_FUN, [1] SEL_ALU, [0] SEL_REG
- `ctrl_MEM`  in  LANES*3;  `ctrl_WB`  in  LANES*2
- `DOA`, `DOB`, `imm_ext`  in  LANES*DATA_W
- `rt`, `rd`  in  LANES*REG_W
- `out_valid`  out  1  execute-side bundle valid
- `out_ready`  in  1  execute accepts the bundle (low = EX stall)
- `lane_valid`  out  LANES
- `ALU_FUN` out LANES*3, `SEL_ALU` out LANES, `SEL_REG` out LANES, `ctrl_MEM_exe` out LANES*3, `ctrl_WB_exe` out LANES*2, `A` out LANES*DATA_W, `DOB_exe` out LANES*DATA_W, `imm_ext_exe` out LANES*DATA_W, `rt_exe` out LANES*REG_W, `rd_exe` out LANES*REG_W
- Lane i occupies slice `[i*W +: W]` of every packed bus.

## Operation
- Accept: the input handshake completes when `in_valid && in_ready && !flush`. Captured lane mask = `lane_valid_in & ~lane_kill`.
- If the captured mask is all-zero, the handshake still completes, nothing is stored, and `out_valid` is unaffected.
- Output: `out_valid = 1` while the main entry holds a bundle. The transfer completes on `out_valid && out_ready`.
- Stall: while `out_valid && !out_ready`, every output is held bit-stable.
- Bubble gating: for a lane with `lane_valid[i]=0`, `ctrl_MEM_exe` and `ctrl_WB_exe` for that lane are forced to 0. Data fields are don't-care.
- Flush has top priority. At the next edge, main and skid entries are invalidated and any same-cycle input is discarded. `flush` overrides `out_ready`, so no transfer is counted.
- Reset values: `out_valid=0`, `lane_valid=0`, all data/control outputs 0, `in_ready=1`.

## Timing
- Latency is 1 cycle from input handshake to `out_valid`.
- Throughput is 1 bundle/cycle when `out_ready` stays high.
- With skid enabled:
  - `in_ready` is a flop; `in_ready = !skid_full`.
  - Main full, stalled, and input accepted: the bundle goes to skid, and `in_ready` falls next cycle.
  - On the next output transfer, skid moves to main the same edge and `in_ready` rises next cycle.
  - Main empty with skid full cannot occur.
- Without skid:
  - `in_ready = !out_valid || out_ready` (combinational).
  - Simultaneous output transfer and input accept replaces main on the same edge with no bubble.
- Reset asserted mid-operation clears all entries immediately (asynchronously). First accept is possible on the first edge after release.

## Configuration
- `ID_EX_SKID_EN` defined: the skid entry is built, `in_ready` is registered, and no combinational path exists from `out_ready` to `in_ready`.
- `ID_EX_SKID_EN` undefined: single entry, combinational `in_ready` as above, smaller area. Port list is identical in both builds.

## Structure
- Package `id_ex_pkg` holds:
  - `CTRL_EXE_W=5`, `CTRL_MEM_W=3`, `CTRL_WB_W=2`.
  - `ctrl_EXE` bit positions: ALU_FUN [4:2], SEL_ALU 1, SEL_REG 0.
  - Per-lane bundle width function.
  - Packed `id_ex_lane_t` typedef.
- Sub-module `id_ex_skid`: a generic one-entry skid buffer over a `WIDTH`-bit payload plus valid, instantiated only under `ID_EX_SKID_EN`.
- Lane field split and bubble gating are done by a generate loop in the top.

## Test plan
- Reset: hold `resetID_n=0` with random inputs -> `out_valid=0`, all outputs 0, `in_ready=1`. Release, then accept a bundle with lane0 DOA=0x12345678, rd=5 -> next cycle `A[31:0]=0x12345678`, `rd_exe[4:0]=5`, `out_valid=1`.
- Streaming: 8 back-to-back bundles with `out_ready=1` -> 8 consecutive `out_valid` cycles in order, no bubbles.
- Stall: `out_ready=0` for 3 cycles while `in_valid=1` -> outputs stable.
  - Skid build: second bundle parked in skid, `in_ready=0` from the following cycle; both bundles later emerge in order.
  - Non-skid build: `in_ready=0` throughout the stall.
- Lane kill: `lane_valid_in=2'b11`, `lane_kill=2'b10`, `ctrl_WB` lane1=2'b11 -> `lane_valid=2'b01`, lane1 `ctrl_WB_exe=0`. All-lanes kill -> `out_valid` stays 0.
- Flush with the skid full and `in_valid=1` -> next cycle `out_valid=0`, skid empty, `in_ready=1`, and the incoming bundle never appears.
- Async reset asserted mid-stall, between clock edges -> outputs clear immediately, with no pending bundle after release.

Source files
------------

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants, field positions and lane layout for the ID/EX pipeline register.
// Contents:
//   CTRL_*_W      control group widths (execute, memory, write-back)
//   ALU_FUN_*     / SEL_ALU_BIT / SEL_REG_BIT: bit positions inside ctrl_EXE
//   lane_bundle_w per-lane payload width for a given data/register width
//   id_ex_lane_t  packed lane layout at the default widths (32-bit data, 5-bit regs)
package id_ex_pkg;

    localparam int unsigned CTRL_EXE_W = 5;
    localparam int unsigned CTRL_MEM_W = 3;
    localparam int unsigned CTRL_WB_W  = 2;

    localparam int unsigned ALU_FUN_LSB = 2;
    localparam int unsigned ALU_FUN_W   = 3;
    localparam int unsigned SEL_ALU_BIT = 1;
    localparam int unsigned SEL_REG_BIT = 0;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;

    // Payload bits carried per lane: three control groups, DOA/DOB/imm_ext, rt/rd.
    function automatic int unsigned lane_bundle_w(input int unsigned data_w,
                                                  input int unsigned reg_w);
        return CTRL_EXE_W + CTRL_MEM_W + CTRL_WB_W + 3 * data_w + 2 * reg_w;
    endfunction

    // Field order matches the per-lane packing in id_ex_pipe (ctrl_exe at the MSB end).
    typedef struct packed {
        logic [CTRL_EXE_W-1:0] ctrl_exe;
        logic [CTRL_MEM_W-1:0] ctrl_mem;
        logic [CTRL_WB_W-1:0]  ctrl_wb;
        logic [DEF_DATA_W-1:0] doa;
        logic [DEF_DATA_W-1:0] dob;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_REG_W-1:0]  rt;
        logic [DEF_REG_W-1:0]  rd;
    } id_ex_lane_t;

endpackage

// File: rtl/id_ex_pipe_skid.sv
// id_ex_skid: generic one-entry skid buffer (payload + valid).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         drop the held entry (highest priority)
//   load_i          capture data_i and mark full
//   drain_i         mark empty (entry consumed this edge)
//   data_i          incoming payload
//   valid_o/data_o  held entry
module id_ex_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register for LANES decoded instruction bundles.
// Valid/ready handshake on both sides, per-lane valid, lane kill at capture, whole-bundle flush.
// Build option: define ID_EX_SKID_EN to add a one-entry skid buffer; in_ready then comes
// straight from a flop (no out_ready -> in_ready path). Without it in_ready is combinational.
// Ports:
//   reloj, resetID_n          clock, asynchronous active-low reset
//   in_valid/in_ready         decode-side handshake
//   lane_valid_in, lane_kill  per-lane presence and squash
//   flush                     squash held and incoming bundles
//   ctrl_EXE/MEM/WB, DOA, DOB, imm_ext, rt, rd   per-lane inputs
//   out_valid/out_ready       execute-side handshake
//   lane_valid, ALU_FUN, SEL_ALU, SEL_REG, ctrl_MEM_exe, ctrl_WB_exe,
//   A, DOB_exe, imm_ext_exe, rt_exe, rd_exe      per-lane outputs
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic                      reloj,
    input  logic                      resetID_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          lane_valid_in,
    input  logic [LANES-1:0]          lane_kill,
    input  logic                      flush,
    input  logic [LANES*5-1:0]        ctrl_EXE,
    input  logic [LANES*3-1:0]        ctrl_MEM,
    input  logic [LANES*2-1:0]        ctrl_WB,
    input  logic [LANES*DATA_W-1:0]   DOA,
    input  logic [LANES*DATA_W-1:0]   DOB,
    input  logic [LANES*DATA_W-1:0]   imm_ext,
    input  logic [LANES*REG_W-1:0]    rt,
    input  logic [LANES*REG_W-1:0]    rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          lane_valid,
    output logic [LANES*3-1:0]        ALU_FUN,
    output logic [LANES-1:0]          SEL_ALU,
    output logic [LANES-1:0]          SEL_REG,
    output logic [LANES*3-1:0]        ctrl_MEM_exe,
    output logic [LANES*2-1:0]        ctrl_WB_exe,
    output logic [LANES*DATA_W-1:0]   A,
    output logic [LANES*DATA_W-1:0]   DOB_exe,
    output logic [LANES*DATA_W-1:0]   imm_ext_exe,
    output logic [LANES*REG_W-1:0]    rt_exe,
    output logic [LANES*REG_W-1:0]    rd_exe
);

    localparam int unsigned LANE_W = lane_bundle_w(DATA_W, REG_W);
    // Lane mask sits above the lane payloads.
    localparam int unsigned PAY_W  = LANES * LANE_W + LANES;

    // Field offsets inside one lane, LSB first.
    localparam int unsigned O_RT  = REG_W;
    localparam int unsigned O_IMM = 2 * REG_W;
    localparam int unsigned O_DOB = O_IMM + DATA_W;
    localparam int unsigned O_DOA = O_DOB + DATA_W;
    localparam int unsigned O_WB  = O_DOA + DATA_W;
    localparam int unsigned O_MEM = O_WB + CTRL_WB_W;
    localparam int unsigned O_EXE = O_MEM + CTRL_MEM_W;

    logic [LANES-1:0] cap_mask;
    logic [PAY_W-1:0] in_pay;
    logic             store;
    logic             tx;
    logic             main_valid_d, main_valid_q;
    logic [PAY_W-1:0] main_pay_d, main_pay_q;

    assign cap_mask = lane_valid_in & ~lane_kill;
    // An all-killed bundle completes the handshake but is never stored.
    assign store    = in_valid & in_ready & ~flush & (|cap_mask);
    assign tx       = main_valid_q & out_ready & ~flush;

    assign in_pay[PAY_W-1 -: LANES] = cap_mask;
    for (genvar i = 0; i < LANES; i++) begin : g_pack
        assign in_pay[i*LANE_W +: LANE_W] = {ctrl_EXE[i*CTRL_EXE_W +: CTRL_EXE_W],
                                             ctrl_MEM[i*CTRL_MEM_W +: CTRL_MEM_W],
                                             ctrl_WB[i*CTRL_WB_W +: CTRL_WB_W],
                                             DOA[i*DATA_W +: DATA_W],
                                             DOB[i*DATA_W +: DATA_W],
                                             imm_ext[i*DATA_W +: DATA_W],
                                             rt[i*REG_W +: REG_W],
                                             rd[i*REG_W +: REG_W]};
    end

`ifdef ID_EX_SKID_EN
    logic             skid_valid;
    logic [PAY_W-1:0] skid_pay;
    logic             skid_load;
    logic             skid_drain;

    // Main is busy and not emptying: park the new bundle.
    assign skid_load  = store & main_valid_q & ~tx;
    assign skid_drain = tx & skid_valid;

    id_ex_skid #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk_i   (reloj),
        .rst_ni  (resetID_n),
        .clear_i (flush),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .data_i  (in_pay),
        .valid_o (skid_valid),
        .data_o  (skid_pay)
    );

    // Pure inversion of the skid valid flop.
    assign in_ready = ~skid_valid;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (tx && skid_valid) begin
            main_pay_d   = skid_pay;
        end else if (store && (!main_valid_q || tx)) begin
            main_valid_d = 1'b1;
            main_pay_d   = in_pay;
        end else if (tx) begin
            main_valid_d = 1'b0;
        end
    end
`else
    assign in_ready = ~main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (store) begin
            main_valid_d = 1'b1;
            main_pay_d   = in_pay;
        end else if (tx) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge reloj or negedge resetID_n) begin
        if (!resetID_n) begin
            main_valid_q <= 1'b0;
            main_pay_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pay_q   <= main_pay_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign lane_valid = main_pay_q[PAY_W-1 -: LANES] & {LANES{main_valid_q}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned B = i * LANE_W;
        assign rd_exe[i*REG_W +: REG_W]        = main_pay_q[B +: REG_W];
        assign rt_exe[i*REG_W +: REG_W]        = main_pay_q[B+O_RT +: REG_W];
        assign imm_ext_exe[i*DATA_W +: DATA_W] = main_pay_q[B+O_IMM +: DATA_W];
        assign DOB_exe[i*DATA_W +: DATA_W]     = main_pay_q[B+O_DOB +: DATA_W];
        assign A[i*DATA_W +: DATA_W]           = main_pay_q[B+O_DOA +: DATA_W];
        assign ALU_FUN[i*ALU_FUN_W +: ALU_FUN_W] =
            main_pay_q[B+O_EXE+ALU_FUN_LSB +: ALU_FUN_W];
        assign SEL_ALU[i] = main_pay_q[B+O_EXE+SEL_ALU_BIT];
        assign SEL_REG[i] = main_pay_q[B+O_EXE+SEL_REG_BIT];
        // Bubble lanes must not write memory or the register file.
        assign ctrl_MEM_exe[i*CTRL_MEM_W +: CTRL_MEM_W] =
            main_pay_q[B+O_MEM +: CTRL_MEM_W] & {CTRL_MEM_W{lane_valid[i]}};
        assign ctrl_WB_exe[i*CTRL_WB_W +: CTRL_WB_W] =
            main_pay_q[B+O_WB +: CTRL_WB_W] & {CTRL_WB_W{lane_valid[i]}};
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    localparam int L = 2;
    localparam int D = 32;
    localparam int R = 5;

    logic           reloj = 1'b0;
    logic           resetID_n;
    logic           in_valid, in_ready, flush, out_valid, out_ready;
    logic [L-1:0]   lane_valid_in, lane_kill, lane_valid, SEL_ALU, SEL_REG;
    logic [L*5-1:0] ctrl_EXE;
    logic [L*3-1:0] ctrl_MEM, ALU_FUN, ctrl_MEM_exe;
    logic [L*2-1:0] ctrl_WB, ctrl_WB_exe;
    logic [L*D-1:0] DOA, DOB, imm_ext, A, DOB_exe, imm_ext_exe;
    logic [L*R-1:0] rt, rd, rt_exe, rd_exe;

    always #5 reloj = ~reloj;

    id_ex_pipe #(.LANES(L), .DATA_W(D), .REG_W(R)) dut (
        .reloj(reloj), .resetID_n(resetID_n), .in_valid(in_valid), .in_ready(in_ready),
        .lane_valid_in(lane_valid_in), .lane_kill(lane_kill), .flush(flush),
        .ctrl_EXE(ctrl_EXE), .ctrl_MEM(ctrl_MEM), .ctrl_WB(ctrl_WB), .DOA(DOA), .DOB(DOB),
        .imm_ext(imm_ext), .rt(rt), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
        .lane_valid(lane_valid), .ALU_FUN(ALU_FUN), .SEL_ALU(SEL_ALU), .SEL_REG(SEL_REG),
        .ctrl_MEM_exe(ctrl_MEM_exe), .ctrl_WB_exe(ctrl_WB_exe), .A(A), .DOB_exe(DOB_exe),
        .imm_ext_exe(imm_ext_exe), .rt_exe(rt_exe), .rd_exe(rd_exe)
    );

    // Reference model: ordered list of bundles held by the register (front = on the outputs).
    typedef struct {
        logic [L-1:0]   mask;
        logic [L*5-1:0] exe;
        logic [L*3-1:0] mem;
        logic [L*2-1:0] wb;
        logic [L*D-1:0] doa, dob, imm;
        logic [L*R-1:0] rt, rd;
    } bundle_t;

    bundle_t q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Capacity 2 with the skid entry (ready while fewer than two held), otherwise
    // capacity 1 and ready when empty or the held bundle leaves this cycle.
    function automatic logic exp_ready();
`ifdef ID_EX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic bundle_t cur_bundle();
        bundle_t b;
        b.mask = lane_valid_in & ~lane_kill;
        b.exe = ctrl_EXE; b.mem = ctrl_MEM; b.wb = ctrl_WB;
        b.doa = DOA; b.dob = DOB; b.imm = imm_ext; b.rt = rt; b.rd = rd;
        return b;
    endfunction

    task automatic compare_outputs(input logic rdy);
        bundle_t b;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() == 0) begin
            check("lane_valid_idle", lane_valid, 0);
            check("mem_idle", ctrl_MEM_exe, 0);
            check("wb_idle", ctrl_WB_exe, 0);
        end else begin
            b = q[0];
            check("lane_valid", lane_valid, b.mask);
            for (int i = 0; i < L; i++) begin
                check($sformatf("mem[%0d]", i), ctrl_MEM_exe[i*3 +: 3],
                      b.mask[i] ? b.mem[i*3 +: 3] : 3'b0);
                check($sformatf("wb[%0d]", i), ctrl_WB_exe[i*2 +: 2],
                      b.mask[i] ? b.wb[i*2 +: 2] : 2'b0);
                if (b.mask[i]) begin
                    check($sformatf("A[%0d]", i), A[i*D +: D], b.doa[i*D +: D]);
                    check($sformatf("DOB[%0d]", i), DOB_exe[i*D +: D], b.dob[i*D +: D]);
                    check($sformatf("imm[%0d]", i), imm_ext_exe[i*D +: D], b.imm[i*D +: D]);
                    check($sformatf("rt[%0d]", i), rt_exe[i*R +: R], b.rt[i*R +: R]);
                    check($sformatf("rd[%0d]", i), rd_exe[i*R +: R], b.rd[i*R +: R]);
                    check($sformatf("alu_fun[%0d]", i), ALU_FUN[i*3 +: 3], b.exe[i*5+2 +: 3]);
                    check($sformatf("sel_alu[%0d]", i), SEL_ALU[i], b.exe[i*5+1]);
                    check($sformatf("sel_reg[%0d]", i), SEL_REG[i], b.exe[i*5]);
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic rdy;
        #2;
        rdy = exp_ready();
        compare_outputs(rdy);
        @(posedge reloj);
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy && |(lane_valid_in & ~lane_kill)) q.push_back(cur_bundle());
        end
        @(negedge reloj);
    endtask

    task automatic rand_data();
        ctrl_EXE = (L*5)'($urandom());
        ctrl_MEM = (L*3)'($urandom());
        ctrl_WB  = (L*2)'($urandom());
        DOA      = {$urandom(), $urandom()};
        DOB      = {$urandom(), $urandom()};
        imm_ext  = {$urandom(), $urandom()};
        rt       = (L*R)'($urandom());
        rd       = (L*R)'($urandom());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_lane_valid"}, lane_valid, 0);
        check({tag, "_ctrl"}, {ALU_FUN, SEL_ALU, SEL_REG, ctrl_MEM_exe, ctrl_WB_exe}, 0);
        check({tag, "_A"}, A, 0);
        check({tag, "_DOB"}, DOB_exe, 0);
        check({tag, "_imm"}, imm_ext_exe, 0);
        check({tag, "_regs"}, {rt_exe, rd_exe}, 0);
    endtask

    initial begin
        resetID_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        lane_valid_in = '0; lane_kill = '0;
        rand_data();

        // Reset held with random inputs toggling.
        for (int c = 0; c < 3; c++) begin
            @(negedge reloj);
            in_valid = 1'b1; out_ready = 1'($urandom());
            lane_valid_in = L'($urandom()); rand_data();
            #2 check_all_zero("reset");
        end

        // Release, then first bundle.
        @(negedge reloj);
        resetID_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; lane_valid_in = 2'b01; lane_kill = '0;
        rand_data();
        DOA[31:0] = 32'h1234_5678; rd[4:0] = 5'd5;
        cycle();
        in_valid = 1'b0;
        #1;
        check("first_A", A[31:0], 32'h1234_5678);
        check("first_rd", rd_exe[4:0], 5);
        check("first_valid", out_valid, 1);
        cycle();

        // Streaming, back-to-back.
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            lane_valid_in = L'($urandom()) | 2'b01;
            rand_data();
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // Stall with input pending, then drain.
        in_valid = 1'b1; lane_valid_in = 2'b11;
        rand_data();
        cycle();
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b0; rand_data();
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();

        // Lane kill.
        in_valid = 1'b1; lane_valid_in = 2'b11; lane_kill = 2'b10;
        rand_data(); ctrl_WB = 4'b1111;
        cycle();
        in_valid = 1'b0; lane_kill = '0;
        #1;
        check("kill_lane_valid", lane_valid, 2'b01);
        check("kill_wb1", ctrl_WB_exe[3:2], 2'b00);
        cycle();
        in_valid = 1'b1; lane_kill = 2'b11; rand_data();
        cycle();
        in_valid = 1'b0; lane_kill = '0;
        #1 check("allkill_out_valid", out_valid, 0);
        cycle();

        // Fill (main + skid where built), then flush with input present.
        out_ready = 1'b0; in_valid = 1'b1; lane_valid_in = 2'b11;
        for (int c = 0; c < 2; c++) begin
            rand_data();
            cycle();
        end
        flush = 1'b1; rand_data();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cycle();
        cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid      = ($urandom() % 4) != 0;
            out_ready     = ($urandom() % 3) != 0;
            lane_valid_in = L'($urandom());
            lane_kill     = (($urandom() % 4) == 0) ? L'($urandom()) : '0;
            flush         = ($urandom() % 20) == 0;
            rand_data();
            cycle();
        end
        flush = 1'b0; lane_kill = '0;

        // Asynchronous reset in the middle of a stall.
        in_valid = 1'b1; out_ready = 1'b0; lane_valid_in = 2'b11;
        rand_data();
        cycle();
        rand_data();
        cycle();
        in_valid = 1'b0;
        #1 resetID_n = 1'b0;
        #1 check_all_zero("async_rst");
        q.delete();
        @(posedge reloj);
        @(negedge reloj);
        resetID_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'($urandom()); out_ready = 1'($urandom());
            lane_valid_in = L'($urandom()); rand_data();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
